// File: rtl/seven_bit_adder_ctrl_pkg.sv
// Shared definitions for the 7-bit adder front-end controller:
// state encodings, state width and push-button bit indices.
package seven_bit_adder_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_ALO  = 3'd0,
    S_AHI  = 3'd1,
    S_BLO  = 3'd2,
    S_BHI  = 3'd3,
    S_ADD  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam int PB_ALO = 0;
  localparam int PB_AHI = 1;
  localparam int PB_BLO = 2;
  localparam int PB_BHI = 3;
  localparam int PB_NUM = 4;

  localparam int OP_W  = 7;
  localparam int RES_W = 8;

endpackage

// File: rtl/seven_bit_adder_ctrl_pb_conditioner.sv
// One push-button conditioner: 2-flop synchronizer, debounce counter and
// a single-cycle press pulse on an accepted 0->1 transition.
module pb_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic pb,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;
  logic          mismatch;
  logic          accept;

  assign mismatch = (sync2 != level);
  // The mismatch has persisted long enough on this cycle to flip the level.
  assign accept   = mismatch && (cnt == CNT_LAST);

  // Two-flop synchronizer for the raw button.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pb;
      sync2 <= sync1;
    end
  end

  // Debounce: count consecutive mismatch cycles, any gap restarts the count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      level <= sync2;
      cnt   <= '0;
    end else if (mismatch) begin
      cnt   <= cnt + 1'b1;
    end else begin
      cnt   <= '0;
    end
  end

  // Press pulse is registered alongside the level change; releases are silent.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      press <= 1'b0;
    end else begin
      press <= accept && sync2;
    end
  end

endmodule

// File: rtl/seven_bit_adder_ctrl.sv
// Front-end controller for the 7-bit adder: conditions four buttons,
// sequences operand entry from the switch bank, and captures the sum.
//
// state  | meaning
// S_ALO  | waiting for PB0, loads a[3:0]
// S_AHI  | waiting for PB1, loads a[6:4]
// S_BLO  | waiting for PB2, loads b[3:0]
// S_BHI  | waiting for PB3, loads b[6:4]
// S_ADD  | one cycle, captures {carry, sum}
// S_DONE | result valid; PB0 starts a new round
module seven_bit_adder_ctrl
  import seven_bit_adder_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [PB_NUM-1:0]  PB,
  input  logic [3:0]         Y,
  output logic [OP_W-1:0]    a,
  output logic [OP_W-1:0]    b,
  input  logic [OP_W-1:0]    sum_in,
  input  logic               carry_in,
  output logic [RES_W-1:0]   result,
  output logic               result_valid,
  output logic [STATE_W-1:0] state
);

  logic [PB_NUM-1:0] press;
  logic [3:0]        y_s1;
  logic [3:0]        y_s2;
  state_t            state_q;
  state_t            state_d;
  logic              ld_alo;
  logic              ld_ahi;
  logic              ld_blo;
  logic              ld_bhi;
  logic              cap_res;
  logic              clr_valid;

  for (genvar i = 0; i < PB_NUM; i++) begin : g_pb
    pb_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_pb (
      .clk  (clk),
      .rstn (rstn),
      .pb   (PB[i]),
      .press(press[i])
    );
  end

  // Two-flop synchronizer for the switch bank.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      y_s1 <= '0;
      y_s2 <= '0;
    end else begin
      y_s1 <= Y;
      y_s2 <= y_s1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_ALO;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and load strobes; only the expected button acts in each state.
  always_comb begin
    state_d   = state_q;
    ld_alo    = 1'b0;
    ld_ahi    = 1'b0;
    ld_blo    = 1'b0;
    ld_bhi    = 1'b0;
    cap_res   = 1'b0;
    clr_valid = 1'b0;
    unique case (state_q)
      S_ALO: begin
        if (press[PB_ALO]) begin
          ld_alo  = 1'b1;
          state_d = S_AHI;
        end
      end
      S_AHI: begin
        if (press[PB_AHI]) begin
          ld_ahi  = 1'b1;
          state_d = S_BLO;
        end
      end
      S_BLO: begin
        if (press[PB_BLO]) begin
          ld_blo  = 1'b1;
          state_d = S_BHI;
        end
      end
      S_BHI: begin
        if (press[PB_BHI]) begin
          ld_bhi  = 1'b1;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        cap_res = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (press[PB_ALO]) begin
          ld_alo    = 1'b1;
          clr_valid = 1'b1;
          state_d   = S_AHI;
        end
      end
      default: begin
        state_d = S_ALO;
      end
    endcase
  end

  // Operand registers; untouched fields keep their previous round's value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a <= '0;
      b <= '0;
    end else begin
      if (ld_alo) a[3:0] <= y_s2;
      if (ld_ahi) a[6:4] <= y_s2[2:0];
      if (ld_blo) b[3:0] <= y_s2;
      if (ld_bhi) b[6:4] <= y_s2[2:0];
    end
  end

  // Result capture; the adder has had a full S_ADD cycle to settle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      result       <= '0;
      result_valid <= 1'b0;
    end else if (cap_res) begin
      result       <= {carry_in, sum_in};
      result_valid <= 1'b1;
    end else if (clr_valid) begin
      result_valid <= 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_seven_bit_adder_ctrl.sv
// Self-checking bench for seven_bit_adder_ctrl with a behavioural adder
// and a sequencing reference model.
module tb_seven_bit_adder_ctrl;

  logic       clk;
  logic       rstn;
  logic [3:0] PB;
  logic [3:0] Y;
  logic [6:0] a;
  logic [6:0] b;
  logic [6:0] sum_in;
  logic       carry_in;
  logic [7:0] result;
  logic       result_valid;
  logic [2:0] state;

  int pass_cnt;
  int total_cnt;

  logic [6:0] exp_a;
  logic [6:0] exp_b;
  logic [7:0] exp_result;
  logic       exp_valid;
  logic [2:0] exp_state;

  // Parent-level adder.
  assign {carry_in, sum_in} = {1'b0, a} + {1'b0, b};

  seven_bit_adder_ctrl #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .PB          (PB),
    .Y           (Y),
    .a           (a),
    .b           (b),
    .sum_in      (sum_in),
    .carry_in    (carry_in),
    .result      (result),
    .result_valid(result_valid),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    exp_a      = '0;
    exp_b      = '0;
    exp_result = '0;
    exp_valid  = 1'b0;
    exp_state  = 3'd0;
  endtask

  // Operand-entry rules: each state waits for one specific button.
  task automatic model_press(input logic [3:0] mask, input logic [3:0] yv);
    int want;
    want = (exp_state == 3'd5) ? 0 : int'(exp_state);
    if (mask[want]) begin
      case (exp_state)
        3'd0, 3'd5: begin exp_a[3:0] = yv; exp_valid = 1'b0; exp_state = 3'd1; end
        3'd1: begin exp_a[6:4] = yv[2:0]; exp_state = 3'd2; end
        3'd2: begin exp_b[3:0] = yv; exp_state = 3'd3; end
        3'd3: begin
          exp_b[6:4] = yv[2:0];
          exp_result = 8'(int'(exp_a) + int'(exp_b));
          exp_valid  = 1'b1;
          exp_state  = 3'd5;
        end
        default: ;
      endcase
    end
  endtask

  // Set switches, hold the buttons 10 cycles, release and let it settle.
  task automatic press(input logic [3:0] mask, input logic [3:0] yv);
    Y = yv;
    repeat (3) @(negedge clk);
    PB = mask;
    repeat (10) @(negedge clk);
    PB = 4'b0;
    repeat (12) @(negedge clk);
    model_press(mask, yv);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rstn = 1'b0;
    PB   = 4'b0;
    Y    = 4'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    total_cnt++;
    if ({a, b, result, result_valid, state} !== 26'b0)
      $display("FAIL reset: a=%h b=%h result=%h valid=%b state=%0d required all zero",
               a, b, result, result_valid, state);
    else pass_cnt++;
  endtask

  task automatic test_full_sequence();
    apply_reset();
    Y = 4'b1101;
    repeat (3) @(negedge clk);
    PB = 4'b0001;
    repeat (6) @(negedge clk);
    total_cnt++;
    if (state !== 3'd0) $display("FAIL latency_early: state=%0d required 0", state);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (state !== 3'd1) $display("FAIL latency_edge: state=%0d required 1", state);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    PB = 4'b0;
    repeat (12) @(negedge clk);
    model_press(4'b0001, 4'b1101);
    press(4'b0010, 4'b1101);
    press(4'b0100, 4'b1101);
    press(4'b1000, 4'b1101);
    total_cnt++;
    if (a !== 7'b1011101 || b !== 7'b1011101 || result !== 8'hBA ||
        result_valid !== 1'b1 || state !== 3'd5)
      $display("FAIL full_sequence: a=%b b=%b result=%h valid=%b state=%0d required a=b=1011101 result=ba valid=1 state=5",
               a, b, result, result_valid, state);
    else pass_cnt++;
  endtask

  task automatic test_second_round();
    press(4'b0001, 4'b1001);
    total_cnt++;
    if (result_valid !== 1'b0 || state !== 3'd1 || result !== 8'hBA)
      $display("FAIL second_round_open: valid=%b state=%0d result=%h required valid=0 state=1 result=ba",
               result_valid, state, result);
    else pass_cnt++;
    press(4'b0010, 4'b1001);
    press(4'b0100, 4'b1001);
    press(4'b1000, 4'b1001);
    total_cnt++;
    if (a !== 7'b0011001 || b !== 7'b0011001 || result !== 8'h32 || result_valid !== 1'b1)
      $display("FAIL second_round: a=%b b=%b result=%h valid=%b required a=b=0011001 result=32 valid=1",
               a, b, result, result_valid);
    else pass_cnt++;
  endtask

  task automatic test_out_of_order();
    apply_reset();
    press(4'b0100, 4'b1111);
    press(4'b1000, 4'b1111);
    total_cnt++;
    if (a !== 7'd0 || b !== 7'd0 || state !== 3'd0)
      $display("FAIL out_of_order: a=%b b=%b state=%0d required a=0 b=0 state=0", a, b, state);
    else pass_cnt++;
    press(4'b0001, 4'b0111);
    total_cnt++;
    if (a[3:0] !== 4'b0111 || state !== 3'd1)
      $display("FAIL out_of_order_load: a_lo=%b state=%0d required 0111 state=1", a[3:0], state);
    else pass_cnt++;
  endtask

  task automatic test_bounce();
    int moves;
    logic [2:0] prev;
    apply_reset();
    Y = 4'b1010;
    repeat (3) @(negedge clk);
    PB = 4'b0001;
    repeat (3) @(negedge clk);
    PB = 4'b0;
    repeat (12) @(negedge clk);
    total_cnt++;
    if (state !== 3'd0 || a !== 7'd0)
      $display("FAIL bounce_reject: state=%0d a=%b required state=0 a=0", state, a);
    else pass_cnt++;
    moves = 0;
    prev  = state;
    PB = 4'b0001;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) PB = 4'b0;
      @(negedge clk);
      if (state !== prev) moves++;
      prev = state;
    end
    model_press(4'b0001, 4'b1010);
    total_cnt++;
    if (moves != 1 || state !== 3'd1 || a !== 7'b0001010)
      $display("FAIL bounce_single: moves=%0d state=%0d a=%b required moves=1 state=1 a=0001010",
               moves, state, a);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    press(4'b0010, 4'b0101);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    total_cnt++;
    if (a !== 7'd0 || state !== 3'd0 || result_valid !== 1'b0)
      $display("FAIL reset_mid: a=%b state=%0d valid=%b required a=0 state=0 valid=0",
               a, state, result_valid);
    else pass_cnt++;
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_carry();
    apply_reset();
    press(4'b0001, 4'b1111);
    press(4'b0010, 4'b1111);
    press(4'b0100, 4'b0001);
    press(4'b1000, 4'b1000);
    total_cnt++;
    if (result !== 8'h80 || result_valid !== 1'b1)
      $display("FAIL carry_max: result=%h valid=%b required 80 valid=1", result, result_valid);
    else pass_cnt++;
    press(4'b0001, 4'b0000);
    press(4'b0010, 4'b0000);
    press(4'b0100, 4'b0000);
    press(4'b1000, 4'b0000);
    total_cnt++;
    if (result !== 8'h00 || result_valid !== 1'b1 || a !== 7'd0 || b !== 7'd0)
      $display("FAIL carry_zero: result=%h valid=%b a=%b b=%b required 00 valid=1 a=b=0",
               result, result_valid, a, b);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [3:0] mask;
    logic [3:0] yv;
    for (int i = 0; i < 40; i++) begin
      mask = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 1) == 1) mask = 4'b0001 << int'(exp_state == 3'd5 ? 3'd0 : exp_state);
      yv = 4'($urandom);
      press(mask, yv);
      total_cnt++;
      if (a !== exp_a || b !== exp_b || result !== exp_result ||
          result_valid !== exp_valid || state !== exp_state)
        $display("FAIL random_%0d: a=%b b=%b result=%h valid=%b state=%0d required a=%b b=%b result=%h valid=%b state=%0d",
                 i, a, b, result, result_valid, state,
                 exp_a, exp_b, exp_result, exp_valid, exp_state);
      else pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rstn = 1'b0;
    PB   = 4'b0;
    Y    = 4'b0;
    model_reset();
    test_reset();
    test_full_sequence();
    test_second_round();
    test_out_of_order();
    test_bounce();
    test_reset_mid();
    test_carry();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
